// File: rtl/fir_serial_mac.sv
`default_nettype none
// ============================================================================
// Module   : fir_serial_mac
// Purpose  : Direct-form FIR filter built around a single time-multiplexed
//            multiplier-accumulator. One sample is accepted in IDLE, the MAC
//            state walks all taps (one product per cycle), and the result is
//            presented in OUT until downstream takes it.
// Ports    : aclk               - clock, rising edge
//            areset             - asynchronous active-high reset
//            s_axis_data_tvalid - input sample valid
//            s_axis_data_tdata  - signed input sample (DATA_W)
//            s_axis_data_tready - block can accept a sample (IDLE only)
//            m_axis_data_tvalid - filter result valid (OUT)
//            m_axis_data_tready - downstream accepts the result
//            m_axis_data_tdata  - signed filter result (ACC_W)
//            coef_we            - coefficient write strobe (honoured in IDLE)
//            coef_addr          - tap index of the coefficient
//            coef_data          - signed coefficient value (COEF_W)
// Revision : 1.0 - initial release
// ============================================================================
module fir_serial_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 19,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_axis_data_tvalid,
  input  logic [DATA_W-1:0]        s_axis_data_tdata,
  output logic                     s_axis_data_tready,
  output logic                     m_axis_data_tvalid,
  input  logic                     m_axis_data_tready,
  output logic [ACC_W-1:0]         m_axis_data_tdata,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_data
);

  localparam int c_addr_w = $clog2(NTAPS);
  localparam int c_cnt_w  = $clog2(NTAPS + 1);
  localparam int c_prod_w = DATA_W + COEF_W;
  localparam logic [c_cnt_w-1:0]  c_last_cnt  = c_cnt_w'(NTAPS);
  localparam logic [c_addr_w:0]   c_ntaps_ext = (c_addr_w + 1)'(NTAPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;

  logic signed [DATA_W-1:0]    r_x    [NTAPS];
  logic signed [COEF_W-1:0]    r_coef [NTAPS];
  logic signed [c_prod_w-1:0]  r_prod;
  logic signed [ACC_W-1:0]     r_acc;
  logic [c_cnt_w-1:0]          r_k;

  logic                        w_in_xfer;
  logic                        w_coef_wr;
  logic                        w_mac_issue;
  logic [c_addr_w-1:0]         w_tap;
  logic signed [c_prod_w-1:0]  w_prod;

  assign w_in_xfer   = s_axis_data_tvalid && (r_state == S_IDLE);
  assign w_coef_wr   = coef_we && (r_state == S_IDLE) &&
                       ({1'b0, coef_addr} < c_ntaps_ext);
  // r_k runs 0..NTAPS: values below NTAPS issue a product, the final value
  // is the drain cycle that folds the last registered product into r_acc.
  assign w_mac_issue = (r_state == S_MAC) && (r_k != c_last_cnt);
  assign w_tap       = w_mac_issue ? r_k[c_addr_w-1:0] : '0;
  assign w_prod      = r_coef[w_tap] * r_x[w_tap];

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (s_axis_data_tvalid)    w_state_next = S_MAC;
      S_MAC:   if (r_k == c_last_cnt)     w_state_next = S_OUT;
      S_OUT:   if (m_axis_data_tready)    w_state_next = S_IDLE;
      default:                            w_state_next = S_IDLE;
    endcase
  end

  // Datapath: coefficient store, delay line, product pipeline, accumulator
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_k    <= '0;
      r_prod <= '0;
      r_acc  <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        r_x[i]    <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      // A write coincident with an accept lands on this edge, so the MAC
      // sweep that starts on the next edge already sees the new value.
      if (w_coef_wr) begin
        r_coef[coef_addr] <= coef_data;
      end

      if (w_in_xfer) begin
        r_x[0] <= s_axis_data_tdata;
        for (int i = 1; i < NTAPS; i++) begin
          r_x[i] <= r_x[i-1];
        end
        r_acc  <= '0;
        r_prod <= '0;
        r_k    <= '0;
      end else if (r_state == S_MAC) begin
        r_acc <= r_acc + ACC_W'(r_prod);
        if (w_mac_issue) begin
          r_prod <= w_prod;
          r_k    <= r_k + c_cnt_w'(1);
        end else begin
          r_prod <= '0;
        end
      end
    end
  end

  // Ready is forced low while reset is held, even though the state is IDLE.
  assign s_axis_data_tready = (r_state == S_IDLE) && !areset;
  assign m_axis_data_tvalid = (r_state == S_OUT);
  assign m_axis_data_tdata  = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_fir_serial_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_serial_mac
// Purpose  : Self-checking bench for fir_serial_mac. A convolution model
//            (coefficient array times sample history) predicts each result;
//            directed impulse/step/backpressure/coefficient/reset scenarios
//            are followed by randomized samples and coefficient updates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_serial_mac;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int NTAPS  = 19;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS);
  localparam int ADDR_W = $clog2(NTAPS);

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              s_tvalid = 1'b0;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tready;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [ACC_W-1:0]  m_tdata;
  logic              coef_we = 1'b0;
  logic [ADDR_W-1:0] coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  longint mc [NTAPS];
  longint hx [NTAPS];
  longint spec_c [NTAPS] = '{26, 270, 963, 2424, 4869, 8259, 12194, 15948, 18666,
                             19660, 18666, 15948, 12194, 8259, 4869, 2424, 963, 270, 26};

  fir_serial_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .NTAPS  (NTAPS)
  ) dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .m_axis_data_tdata  (m_tdata),
    .coef_we            (coef_we),
    .coef_addr          (coef_addr),
    .coef_data          (coef_data)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint rand16();
    logic [15:0] r;
    r = 16'($urandom);
    return longint'($signed(r));
  endfunction

  function automatic longint dut_out();
    return longint'($signed(m_tdata));
  endfunction

  // y[n] = sum_k c[k] * x[n-k]
  function automatic longint model_out();
    longint s = 0;
    for (int k = 0; k < NTAPS; k++) s += mc[k] * hx[k];
    return s;
  endfunction

  task automatic model_push(input longint d);
    for (int k = NTAPS - 1; k > 0; k--) hx[k] = hx[k-1];
    hx[0] = d;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NTAPS; k++) begin
      mc[k] = 0;
      hx[k] = 0;
    end
  endtask

  task automatic write_coef(input int addr, input longint val);
    coef_we   = 1'b1;
    coef_addr = ADDR_W'(addr);
    coef_data = COEF_W'(val);
    @(posedge aclk); #1;
    coef_we = 1'b0;
    if (addr < NTAPS) mc[addr] = val;
  endtask

  // wr_mode: 0 none, 1 write coincident with accept, 2 write during MAC
  task automatic do_sample(input longint d, input int hold, input int wr_mode,
                           input int wr_addr, input longint wr_data,
                           output longint obs);
    longint exp_v;
    int cyc;
    m_tready = (hold == 0);
    s_tvalid = 1'b1;
    s_tdata  = DATA_W'(d);
    if (wr_mode == 1) begin
      coef_we   = 1'b1;
      coef_addr = ADDR_W'(wr_addr);
      coef_data = COEF_W'(wr_data);
    end
    cyc = 0;
    while (s_tready !== 1'b1 && cyc < 100) begin
      @(posedge aclk); #1;
      cyc++;
    end
    chk("ready_before_accept", s_tready, 1);
    @(posedge aclk); #1;
    coef_we = 1'b0;
    if (wr_mode == 1 && wr_addr < NTAPS) mc[wr_addr] = wr_data;
    model_push(d);
    exp_v = model_out();
    // junk offered while busy must never be taken
    s_tdata = DATA_W'($urandom);
    cyc = 0;
    while (m_tvalid !== 1'b1 && cyc < 100) begin
      @(posedge aclk); #1;
      cyc++;
      if (cyc == 3 && wr_mode == 2) begin
        coef_we   = 1'b1;
        coef_addr = ADDR_W'(wr_addr);
        coef_data = COEF_W'(wr_data);
      end else begin
        coef_we = 1'b0;
      end
    end
    coef_we = 1'b0;
    chk("latency", cyc, NTAPS + 1);
    obs = dut_out();
    chk("result", obs, exp_v);
    for (int i = 0; i < hold; i++) begin
      @(posedge aclk); #1;
      chk("hold_data", dut_out(), exp_v);
      chk("hold_in_ready", s_tready, 0);
      chk("hold_valid", m_tvalid, 1);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(posedge aclk); #1;
    chk("valid_dropped", m_tvalid, 0);
    chk("ready_again", s_tready, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint obs;
    int     mode;
    int     seen;
    model_clear();

    // Reset state
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_in_ready", s_tready, 0);
    chk("rst_out_valid", m_tvalid, 0);
    chk("rst_out_data", dut_out(), 0);
    areset = 1'b0;
    @(posedge aclk); #1;
    chk("ready_after_reset", s_tready, 1);

    // Coefficient load; out-of-range address must be ignored
    for (int k = 0; k < NTAPS; k++) write_coef(k, spec_c[k]);
    write_coef(NTAPS, 12345);

    // Impulse response
    for (int i = 0; i < NTAPS; i++) begin
      do_sample((i == 0) ? 1 : 0, 0, 0, 0, 0, obs);
      chk("impulse", obs, spec_c[i]);
    end

    // Step responses
    for (int i = 0; i < NTAPS; i++) do_sample(32767, 0, 0, 0, 0, obs);
    chk("step_pos", obs, 64'sd4813406766);
    for (int i = 0; i < NTAPS; i++) do_sample(-32768, 0, 0, 0, 0, obs);
    chk("step_neg", obs, -64'sd4813553664);

    // Backpressure for 5 cycles, then ordinary samples to expose any
    // lost or duplicated input
    do_sample(rand16(), 5, 0, 0, 0, obs);
    do_sample(rand16(), 0, 0, 0, 0, obs);
    do_sample(rand16(), 2, 0, 0, 0, obs);

    // Coefficient write during MAC is dropped; coincident write is used
    do_sample(rand16(), 0, 2, 4, -777, obs);
    do_sample(rand16(), 0, 0, 0, 0, obs);
    do_sample(rand16(), 0, 1, 0, -555, obs);
    do_sample(rand16(), 0, 0, 0, 0, obs);

    // Randomized samples, holds and coefficient traffic
    for (int i = 0; i < 30; i++) begin
      mode = 0;
      if ($urandom_range(0, 3) == 0) mode = int'($urandom_range(1, 2));
      do_sample(rand16(), int'($urandom_range(0, 2)), mode,
                int'($urandom_range(0, NTAPS)), rand16(), obs);
    end

    // Reset in the middle of MAC
    s_tvalid = 1'b1;
    s_tdata  = 16'd1;
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    repeat (7) @(posedge aclk);
    #1;
    areset = 1'b1;
    #1;
    chk("midrst_out_valid", m_tvalid, 0);
    chk("midrst_out_data", dut_out(), 0);
    chk("midrst_in_ready", s_tready, 0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    model_clear();
    @(posedge aclk); #1;
    chk("ready_after_midrst", s_tready, 1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge aclk); #1;
      if (m_tvalid !== 1'b0) seen++;
    end
    chk("no_partial_result", seen, 0);

    // Coefficients were cleared: impulse yields zeros until reloaded
    for (int i = 0; i < NTAPS; i++) begin
      do_sample((i == 0) ? 1 : 0, 0, 0, 0, 0, obs);
      chk("impulse_no_reload", obs, 0);
    end
    for (int k = 0; k < NTAPS; k++) write_coef(k, spec_c[k]);
    for (int i = 0; i < NTAPS; i++) begin
      do_sample((i == 0) ? 1 : 0, 0, 0, 0, 0, obs);
      chk("impulse_reload", obs, spec_c[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
